tt_um_segment_to_onehot_decoder: RTL and testbench

//   Inverse of the priority-encoder/7-segment path: samples a segment bus (gfedcba + "none" dp),

---
 rtl/seg7_pkg.sv | 25 ++
 rtl/seg7_pattern_decode.sv | 32 +++
 rtl/tt_um_segment_to_onehot_decoder.sv | 98 +++++++++
 tb/tb_tt_um_segment_to_onehot_decoder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: digit glyph table, blank glyph and the
// {none,seg} pattern type used on both the encoder and decoder paths.
package seg7_pkg;

    localparam int NUM_DIGITS = 8;

    typedef logic [6:0] seg_t;

    typedef struct packed {
        logic none;
        seg_t seg;
    } pattern_t;

    // Glyphs in gfedcba order, bit 0 = segment a.
    localparam seg_t SEG_DIGIT [0:NUM_DIGITS-1] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07
    };

    localparam seg_t SEG_BLANK = 7'h00;

    function automatic logic [7:0] onehot8(input logic [2:0] code);
        onehot8 = 8'b1 << code;
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational glyph decoder: classifies a {none,seg} pattern as one of the
// eight digits, the blank indication, or an invalid pattern.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  pattern_t   pat,
    output logic [2:0] code,
    output logic       is_none,
    output logic       is_invalid
);

    always_comb begin
        code       = 3'd0;
        is_none    = 1'b0;
        is_invalid = 1'b1;
        if (pat.none) begin
            // The dp only means "blank" when no segment is lit alongside it.
            if (pat.seg == SEG_BLANK) begin
                is_none    = 1'b1;
                is_invalid = 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (pat.seg == SEG_DIGIT[i]) begin
                    code       = 3'(i);
                    is_invalid = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/tt_um_segment_to_onehot_decoder.sv
// Receive side of a 7-segment link: debounces the segment bus, decodes each new
// stable glyph to a code / one-hot word and hands it out over valid/ready.
module tt_um_segment_to_onehot_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_in,
    input  logic       none_in,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic [2:0] out_code,
    output logic       out_none,
    output logic       err
);

    localparam int CNT_W = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    pattern_t         sample;
    pattern_t         s_q;
    pattern_t         acc_q;
    logic             acc_empty;
    logic [CNT_W-1:0] cnt;

    logic             stable;
    logic             is_new;
    logic             xfer;
    logic             accept;

    logic [2:0]       dec_code;
    logic             dec_none;
    logic             dec_invalid;

    assign sample = {none_in, seg_in};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q <= '0;
            cnt <= '0;
        end else begin
            s_q <= sample;
            if (sample != s_q) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // The counter saturates, so a pattern blocked by back-pressure stays
    // eligible and is taken on the transfer edge.
    assign stable = (cnt == CNT_MAX);
    assign is_new = acc_empty || (s_q != acc_q);
    assign xfer   = out_valid && out_ready;
    assign accept = stable && is_new && (!out_valid || out_ready);

    seg7_pattern_decode u_decode (
        .pat        (s_q),
        .code       (dec_code),
        .is_none    (dec_none),
        .is_invalid (dec_invalid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            acc_empty <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_code  <= '0;
            out_none  <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b0;
            end
            // Invalid glyphs are remembered so they flag err only once and
            // never reach the output.
            if (accept) begin
                acc_q     <= s_q;
                acc_empty <= 1'b0;
                if (dec_invalid) begin
                    err <= 1'b1;
                end else begin
                    out_valid <= 1'b1;
                    out_code  <= dec_code;
                    out_none  <= dec_none;
                    out_data  <= dec_none ? 8'h00 : onehot8(dec_code);
                end
            end
        end
    end

endmodule

// File: tb/tb_tt_um_segment_to_onehot_decoder.sv
// Bench for the segment-to-one-hot decoder: directed scenarios followed by
// randomized glyph streams, all checked against a window-based reference model.
module tb_tt_um_segment_to_onehot_decoder;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg_in;
    logic       none_in;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [2:0] out_code;
    logic       out_none;
    logic       err;

    always #5 clk = ~clk;

    tt_um_segment_to_onehot_decoder #(.STABLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_in    (seg_in),
        .none_in   (none_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_code  (out_code),
        .out_none  (out_none),
        .err       (err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: a pattern is stable once the last S samples agree.
    logic [7:0] hist[$];
    logic [7:0] m_acc;
    bit         m_empty;
    bit         m_vld;
    bit         m_none;
    bit         m_err;
    int         m_code;
    int         m_data;
    int         xfers[$];
    bit         rnd_ready = 1'b0;

    function automatic int ref_decode(input logic [7:0] p);
        int digits[8] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07};
        if (p == 8'h80) return 8;
        for (int i = 0; i < 8; i++)
            if (p == 8'(digits[i])) return i;
        return -1;
    endfunction

    task automatic model_reset();
        hist.delete();
        hist.push_back(8'h00);
        m_acc   = 8'h00;
        m_empty = 1'b1;
        m_vld   = 1'b0;
        m_none  = 1'b0;
        m_err   = 1'b0;
        m_code  = 0;
        m_data  = 0;
    endtask

    task automatic model_edge(input logic [7:0] smp, input bit rdy);
        bit stable;
        bit accept;
        int d;
        stable = (hist.size() >= S);
        if (stable)
            for (int i = 0; i < hist.size(); i++)
                if (hist[i] != hist[hist.size()-1]) stable = 1'b0;
        accept = stable && (m_empty || hist[hist.size()-1] != m_acc) && (!m_vld || rdy);
        if (m_vld && rdy) m_vld = 1'b0;
        if (accept) begin
            m_acc   = hist[hist.size()-1];
            m_empty = 1'b0;
            d = ref_decode(m_acc);
            if (d < 0) begin
                m_err = 1'b1;
            end else begin
                m_vld  = 1'b1;
                m_none = (d == 8);
                m_code = (d == 8) ? 0 : d;
                m_data = (d == 8) ? 0 : (2 ** d);
            end
        end
        hist.push_back(smp);
        if (hist.size() > S) void'(hist.pop_front());
    endtask

    task automatic compare_all(input string ph);
        check({ph, "_valid"}, 32'(out_valid), 32'(m_vld));
        check({ph, "_code"},  32'(out_code),  32'(m_code));
        check({ph, "_data"},  32'(out_data),  32'(m_data));
        check({ph, "_none"},  32'(out_none),  32'(m_none));
        check({ph, "_err"},   32'(err),       32'(m_err));
    endtask

    // Called at a falling edge; advances one clock and checks the outputs.
    task automatic step(input string ph);
        bit rdy;
        rdy = out_ready;
        if (out_valid && out_ready) xfers.push_back(out_none ? 8 : int'(out_code));
        @(posedge clk);
        model_edge({none_in, seg_in}, rdy);
        @(negedge clk);
        compare_all(ph);
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic hold(input logic [7:0] p, input int n, input string ph);
        none_in = p[7];
        seg_in  = p[6:0];
        repeat (n) step(ph);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        compare_all("rst");
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [7:0] pool[12] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                             8'h80, 8'h7F, 8'h00, 8'hBF};

    initial begin
        rst       = 1'b1;
        seg_in    = 7'h5B;
        none_in   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);

        // 1: latency and first decode
        do_reset();
        repeat (4) step("t1");
        check("t1_not_yet", 32'(out_valid), 32'd0);
        step("t1");
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_code", 32'(out_code), 32'd2);
        check("t1_data", 32'(out_data), 32'h04);

        // 2: blank
        hold(8'h80, 5, "t2");
        check("t2_valid", 32'(out_valid), 32'd1);
        check("t2_none", 32'(out_none), 32'd1);
        check("t2_data", 32'(out_data), 32'h00);
        check("t2_code", 32'(out_code), 32'd0);
        check("t2_err", 32'(err), 32'd0);
        step("t2");

        // 3: back-pressure then back-to-back delivery
        out_ready = 1'b0;
        hold(8'h66, 5, "t3");
        hold(8'h07, 6, "t3");
        check("t3_held_code", 32'(out_code), 32'd4);
        check("t3_held_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        step("t3");
        check("t3_b2b_valid", 32'(out_valid), 32'd1);
        check("t3_b2b_code", 32'(out_code), 32'd7);
        check("t3_b2b_data", 32'(out_data), 32'h80);
        step("t3");

        // 4: glitch does not cause a repeat
        xfers.delete();
        hold(8'h06, 6, "t4");
        hold(8'h7D, 3, "t4");
        hold(8'h06, 6, "t4");
        check("t4_count", 32'(xfers.size()), 32'd1);
        if (xfers.size() > 0) check("t4_code", 32'(xfers[0]), 32'd1);

        // 5: invalid pattern sets sticky err
        xfers.delete();
        hold(8'h7F, 6, "t5");
        check("t5_err", 32'(err), 32'd1);
        check("t5_valid", 32'(out_valid), 32'd0);
        hold(8'h3F, 6, "t5");
        check("t5_count", 32'(xfers.size()), 32'd1);
        if (xfers.size() > 0) check("t5_code", 32'(xfers[0]), 32'd0);
        check("t5_err_sticky", 32'(err), 32'd1);

        // 6: async reset mid-transaction, same pattern re-emitted
        out_ready = 1'b0;
        hold(8'h6D, 5, "t6");
        check("t6_valid", 32'(out_valid), 32'd1);
        check("t6_code", 32'(out_code), 32'd5);
        do_reset();
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_err", 32'(err), 32'd0);
        out_ready = 1'b1;
        hold(8'h6D, 5, "t6");
        check("t6_re_valid", 32'(out_valid), 32'd1);
        check("t6_re_code", 32'(out_code), 32'd5);

        // Randomized glyph streams with random back-pressure
        rnd_ready = 1'b1;
        repeat (400) begin
            if ($urandom_range(0, 49) == 0) do_reset();
            hold(pool[$urandom_range(0, 11)], int'($urandom_range(1, 7)), "rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
